// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer
// Holds the sprite attribute table (Avalon-MM slave). Once per scanline it builds
// the sprites for the upcoming line into one bank of a double-buffered line
// buffer. It streams the other bank out as 2-bit colour indices that line up
// with hcount/vcount. Index 0 means transparent/background.

module sprite_line_renderer #(
    parameter int unsigned NSPRITES   = 8,
    parameter int unsigned SPRITE_W   = 16,
    parameter int unsigned SPRITE_H   = 16,
    parameter int unsigned HACTIVE_PX = 640,
    parameter int unsigned VACTIVE_LN = 480,
    parameter int unsigned VTOTAL     = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [7:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic [1:0]  pix_cidx,
    output logic        render_overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_DRAW  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [10:0] TRIG_H    = 11'd1599;
    localparam logic [9:0]  HACT10    = 10'(HACTIVE_PX);
    localparam logic [10:0] HACT11    = 11'(HACTIVE_PX);
    localparam logic [9:0]  VACT10    = 10'(VACTIVE_LN);
    localparam logic [9:0]  VTOT_M1   = 10'(VTOTAL - 1);
    localparam logic [10:0] SPR_H11   = 11'(SPRITE_H);
    localparam logic [9:0]  CLR_LAST  = 10'(HACTIVE_PX - 1);
    localparam logic [9:0]  DRAW_LAST = 10'(SPRITE_W - 1);
    localparam logic [2:0]  SLOT_TOP  = 3'(NSPRITES - 1);

    // Sprite attribute table
    logic [9:0]          attr_x_q   [NSPRITES];
    logic [9:0]          attr_y_q   [NSPRITES];
    logic [3:0]          attr_pat_q [NSPRITES];
    logic [NSPRITES-1:0] attr_en_q;

    // Builder state
    logic [2:0]  state_q;
    logic [2:0]  slot_q;
    logic [9:0]  t_q;
    logic [9:0]  cnt_q;
    logic [31:0] row_q;
    logic [9:0]  cur_x_q;
    logic [7:0]  rom_addr_q;
    logic        overrun_q;
    logic [1:0]  bank_valid_q;

    // Line buffer banks and display pipeline
    logic [1:0]  lb0 [HACTIVE_PX];
    logic [1:0]  lb1 [HACTIVE_PX];
    logic [1:0]  rd_data_q;
    logic        blank_q;
    logic [1:0]  pix_q;

    logic        trig;
    logic [9:0]  t_next;
    logic [10:0] scan_diff;
    logic        scan_hit;
    logic [7:0]  scan_addr;
    logic [1:0]  draw_pix;
    logic [10:0] draw_col;
    logic        lb_we;
    logic [9:0]  lb_col;
    logic [1:0]  lb_wdata;
    logic [10:0] rd_h;
    logic [9:0]  rd_col;
    logic        unused_bits;

    assign trig   = (hcount == TRIG_H);
    assign t_next = (vcount == VTOT_M1) ? '0 : vcount + 10'd1;
    assign rd_h   = hcount + 11'd2;
    assign rd_col = rd_h[10:1];

    assign pix_cidx       = pix_q;
    assign render_overrun = overrun_q;
    assign unused_bits    = ^{writedata[30:24], rd_h[0]};

    // Avalon write into the attribute table; reset disables every slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NSPRITES; i++) begin
                attr_x_q[i]   <= '0;
                attr_y_q[i]   <= '0;
                attr_pat_q[i] <= '0;
            end
            attr_en_q <= '0;
        end else if (chipselect && write && (32'(address) < NSPRITES)) begin
            attr_x_q[address]   <= writedata[9:0];
            attr_y_q[address]   <= writedata[19:10];
            attr_pat_q[address] <= writedata[23:20];
            attr_en_q[address]  <= writedata[31];
        end
    end

    // Vertical hit test for the slot under scan; ROM address is presented during SCAN
    // and held afterwards, so the row arrives in time to be latched during FETCH
    always_comb begin
        scan_diff = {1'b0, t_q} - {1'b0, attr_y_q[slot_q]};
        scan_hit  = attr_en_q[slot_q]
                    && ({1'b0, t_q} >= {1'b0, attr_y_q[slot_q]})
                    && (scan_diff < SPR_H11);
        scan_addr = {attr_pat_q[slot_q], scan_diff[3:0]};
        rom_addr  = (state_q == S_SCAN) ? scan_addr : rom_addr_q;
    end

    // Line buffer write port: clear sweep, then opaque, on-screen sprite pixels only
    always_comb begin
        draw_pix = row_q[{cnt_q[3:0], 1'b0} +: 2];
        draw_col = {1'b0, cur_x_q} + {7'b0, cnt_q[3:0]};
        lb_we    = 1'b0;
        lb_col   = cnt_q;
        lb_wdata = 2'b00;
        case (state_q)
            S_CLEAR: lb_we = 1'b1;
            S_DRAW: begin
                if ((draw_pix != 2'b00) && (draw_col < HACT11)) begin
                    lb_we    = 1'b1;
                    lb_col   = draw_col[9:0];
                    lb_wdata = draw_pix;
                end
            end
            default: ;
        endcase
    end

    // Line build FSM; an end-of-line trigger always restarts the build, flagging an overrun
    // and invalidating the target bank if the previous build had not finished
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            t_q          <= '0;
            cnt_q        <= '0;
            row_q        <= '0;
            cur_x_q      <= '0;
            rom_addr_q   <= '0;
            overrun_q    <= 1'b0;
            bank_valid_q <= '0;
        end else begin
            rom_addr_q <= rom_addr;
            if (trig) begin
                t_q     <= t_next;
                cnt_q   <= '0;
                state_q <= S_CLEAR;
                if (state_q != S_IDLE) begin
                    overrun_q              <= 1'b1;
                    bank_valid_q[t_next[0]] <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_CLEAR: begin
                        if (cnt_q == CLR_LAST) begin
                            cnt_q   <= '0;
                            slot_q  <= SLOT_TOP;
                            state_q <= S_SCAN;
                        end else begin
                            cnt_q <= cnt_q + 10'd1;
                        end
                    end
                    S_SCAN: begin
                        cur_x_q <= attr_x_q[slot_q];
                        state_q <= scan_hit ? S_FETCH : S_NEXT;
                    end
                    S_FETCH: begin
                        row_q   <= rom_data;
                        cnt_q   <= '0;
                        state_q <= S_DRAW;
                    end
                    S_DRAW: begin
                        if (cnt_q == DRAW_LAST) begin
                            state_q <= S_NEXT;
                        end else begin
                            cnt_q <= cnt_q + 10'd1;
                        end
                    end
                    S_NEXT: begin
                        if (slot_q == 3'd0) begin
                            state_q <= S_DONE;
                        end else begin
                            slot_q  <= slot_q - 3'd1;
                            state_q <= S_SCAN;
                        end
                    end
                    S_DONE: begin
                        if (t_q < VACT10) begin
                            bank_valid_q[t_q[0]] <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Line buffer RAM: builder writes the build bank, display reads the display bank (registered)
    always_ff @(posedge clk) begin
        if (lb_we) begin
            if (t_q[0]) begin
                lb1[lb_col] <= lb_wdata;
            end else begin
                lb0[lb_col] <= lb_wdata;
            end
        end
        if (rd_col < HACT10) begin
            rd_data_q <= vcount[0] ? lb1[rd_col] : lb0[rd_col];
        end
    end

    // Output stage; the blank decision travels alongside the RAM read so both line up
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_q <= 1'b1;
            pix_q   <= 2'b00;
        end else begin
            blank_q <= (vcount >= VACT10) || (rd_col >= HACT10) || !bank_valid_q[vcount[0]];
            pix_q   <= blank_q ? 2'b00 : rd_data_q;
        end
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer: drives hcount/vcount directly,
// models the pattern ROM, and compares every displayed pixel of selected lines
// against hand-written expected column ranges.
`timescale 1ns/1ps

module tb_sprite_line_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] writedata;
    logic        write;
    logic        chipselect;
    logic [2:0]  address;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic [1:0]  pix_cidx;
    logic        render_overrun;

    logic [31:0] rom_mem [256];
    logic [1:0]  exp_col [640];
    int          total = 0;
    int          bad   = 0;

    sprite_line_renderer dut (
        .clk            (clk),
        .reset          (reset),
        .writedata      (writedata),
        .write          (write),
        .chipselect     (chipselect),
        .address        (address),
        .hcount         (hcount),
        .vcount         (vcount),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .pix_cidx       (pix_cidx),
        .render_overrun (render_overrun)
    );

    always #10 clk = ~clk;

    // synchronous pattern ROM: data valid one cycle after the address
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_clear();
        for (int i = 0; i < 640; i++) exp_col[i] = 2'b00;
    endtask

    task automatic exp_fill(input int lo, input int hi, input logic [1:0] val);
        for (int i = lo; i <= hi; i++) exp_col[i] = val;
    endtask

    task automatic wr_slot(input int slot, input logic en, input int x, input int y, input int pat);
        step();
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 3'(slot);
        writedata  = {en, 7'h55, 4'(pat), 10'(y), 10'(x)};
        step();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    // end-of-line trigger on line v, then enough idle time for the worst-case build
    task automatic build(input int v);
        step();
        vcount = 10'(v);
        hcount = 11'd1599;
        step();
        hcount = 11'd0;
        repeat (900) step();
    endtask

    // sweep hcount across line v and compare each pixel with exp_col
    task automatic show(input int v, input string tag);
        int c;
        logic [1:0] e;
        step();
        vcount = 10'(v);
        hcount = 11'd0;
        repeat (3) step();
        for (int h = 1; h <= 1598; h++) begin
            step();
            hcount = 11'(h);
            @(negedge clk);
            if (h >= 2) begin
                c = h / 2;
                e = ((v >= 480) || (c >= 640)) ? 2'b00 : exp_col[c];
                chk($sformatf("%s h%0d", tag, h), 32'(pix_cidx), 32'(e));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 256; a++) rom_mem[a] = '0;
        for (int r = 0; r < 16; r++) begin
            rom_mem[8'(2 * 16 + r)] = (r == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
            rom_mem[8'(3 * 16 + r)] = 32'hAAAA_AAAA;
            rom_mem[8'(4 * 16 + r)] = 32'hFFFF_FFFF;
            rom_mem[8'(5 * 16 + r)] = 32'h0000_0000;
            rom_mem[8'(6 * 16 + r)] = 32'h1B1B_1B1B;
        end

        reset = 1'b1; writedata = '0; write = 1'b0; chipselect = 1'b0;
        address = '0; hcount = '0; vcount = '0;
        repeat (3) step();
        chk("rst_pix", 32'(pix_cidx), 32'd0);
        chk("rst_ovr", 32'(render_overrun), 32'd0);
        chk("rst_rom", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        exp_clear();
        show(10, "L10_nobuild");

        // single sprite, row 0 and row 15
        wr_slot(0, 1'b1, 100, 50, 2);
        build(49);
        exp_clear(); exp_fill(100, 115, 2'd1);
        show(50, "L50_basic");

        // async reset while a build is clearing the other bank
        step(); vcount = 10'd50; hcount = 11'd1599;
        step(); hcount = 11'd200;
        repeat (50) step();
        @(negedge clk);
        chk("pre_rst_pix", 32'(pix_cidx), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_pix", 32'(pix_cidx), 32'd0);
        chk("rst_async_rom", 32'(rom_addr), 32'd0);
        chk("rst_async_ovr", 32'(render_overrun), 32'd0);
        repeat (3) step();
        reset = 1'b0;
        exp_clear();
        show(50, "L50_after_rst");
        build(49);
        show(50, "L50_en_cleared");

        wr_slot(0, 1'b1, 100, 50, 2);
        build(49);
        exp_clear(); exp_fill(100, 115, 2'd1);
        show(50, "L50_rebuilt");
        build(64);
        exp_clear(); exp_fill(100, 115, 2'd2);
        show(65, "L65_row15");
        build(48);
        exp_clear();
        show(49, "L49_above");
        build(65);
        show(66, "L66_below");

        // priority and transparency
        wr_slot(1, 1'b1, 100, 50, 4);
        wr_slot(0, 1'b1, 100, 50, 3);
        build(49);
        exp_clear(); exp_fill(100, 115, 2'd2);
        show(50, "L50_prio");
        wr_slot(0, 1'b1, 100, 50, 5);
        build(49);
        exp_clear(); exp_fill(100, 115, 2'd3);
        show(50, "L50_transp");
        wr_slot(0, 1'b1, 104, 50, 6);
        build(49);
        exp_clear(); exp_fill(100, 115, 2'd3);
        for (int col = 104; col <= 119; col++) begin
            case ((col - 104) % 4)
                0: exp_col[col] = 2'd3;
                1: exp_col[col] = 2'd2;
                2: exp_col[col] = 2'd1;
                default: ;
            endcase
        end
        show(50, "L50_mixed");

        // horizontal clipping and bottom edge
        wr_slot(1, 1'b0, 0, 0, 0);
        wr_slot(0, 1'b1, 630, 50, 3);
        build(49);
        exp_clear(); exp_fill(630, 639, 2'd2);
        show(50, "L50_clip");
        wr_slot(0, 1'b1, 200, 470, 3);
        build(478);
        exp_clear(); exp_fill(200, 215, 2'd2);
        show(479, "L479_bottom");
        build(479);
        exp_clear();
        show(480, "L480_vblank");

        // frame wrap with all eight slots hitting line 0
        for (int k = 0; k < 8; k++) wr_slot(k, 1'b1, 40 * k + 5, 0, (k % 2 == 0) ? 3 : 4);
        build(524);
        chk("ovr_8hits", 32'(render_overrun), 32'd0);
        exp_clear();
        for (int k = 0; k < 8; k++) exp_fill(40 * k + 5, 40 * k + 20, (k % 2 == 0) ? 2'd2 : 2'd3);
        show(0, "L0_wrap");

        // forced overrun: second trigger lands mid-build
        step(); vcount = 10'd524; hcount = 11'd1599;
        step(); hcount = 11'd0;
        repeat (100) step();
        hcount = 11'd1599;
        step(); hcount = 11'd0;
        repeat (900) step();
        chk("ovr_set", 32'(render_overrun), 32'd1);
        show(0, "L0_restart");
        build(524);
        chk("ovr_sticky", 32'(render_overrun), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
- Upstream neighbour of the PPU colour stage. Holds the sprite attribute table written over the Avalon-MM slave.
- During each scanline it renders the sprites for the next line into one bank of a double-buffered line buffer. In the same line it streams the other bank out as 2-bit colour indices aligned to hcount/vcount.
- The PPU maps each index to RGB; index 0 selects the background colour.

Parameters:
- NSPRITES, 8, number of sprite attribute slots (max 8; address is 3 bits).
- SPRITE_W, 16, sprite width in pixels (2 bits per pixel in the ROM row).
- SPRITE_H, 16, sprite height in rows.
- HACTIVE_PX, 640, visible columns.
- VACTIVE_LN, 480, visible lines.
- VTOTAL, 525, lines per frame.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- writedata  in  32  attribute word: [9:0] x, [19:10] y, [23:20] pattern, [31] enable; other bits ignored.
- write  in  1  Avalon write strobe.
- chipselect  in  1  Avalon chip select.
- address  in  3  sprite slot index.
- hcount  in  11  from vga_counters; pixel column = hcount[10:1].
- vcount  in  10  from vga_counters; pixel row.
- rom_addr  out  8  pattern ROM address {pattern, row[3:0]}.
- rom_data  in  32  pattern row; pixel i = rom_data[2i+1:2i]; valid 1 cycle after rom_addr.
- pix_cidx  out  2  colour index for current pixel; 0 = transparent/background.
- render_overrun  out  1  sticky flag: a line build was aborted.

Behaviour:
- Reset (async):
  - all attribute slots cleared (enable=0); FSM to IDLE.
  - pix_cidx=0, rom_addr=0, render_overrun=0, both bank_valid bits=0.
  - line buffer RAM is not cleared.
- Attribute write: on chipselect && write, slot[address] <= writedata fields, effective the next cycle. A sprite's attributes are sampled when the FSM reaches SCAN for that slot.
- Line buffer: two banks of 640 x 2 bits. Build bank = t[0], where t = (vcount == VTOTAL-1) ? 0 : vcount+1. Display bank = vcount[0].
- Build trigger: hcount == 1599 (end of line). Computes t for the upcoming line.
  - If FSM is not IDLE at the trigger: abort the build, set render_overrun, clear bank_valid[build bank], then restart.
- FSM:
  - IDLE: on trigger -> CLEAR.
  - CLEAR: write 0 to columns 0..639 of the build bank, one per cycle (640 cycles) -> SCAN with slot = NSPRITES-1.
  - SCAN: hit = enable && t >= y && (t - y) < SPRITE_H, compared in 11 bits, no wrap. On hit, drive rom_addr and go -> FETCH. On miss, go -> NEXT.
  - FETCH: 1 wait cycle; latch rom_data -> DRAW with i = 0.
  - DRAW: SPRITE_W cycles. Pixel i is written at column x+i only if it is nonzero and x+i < 640; off-screen pixels are clipped -> NEXT.
  - NEXT: if slot == 0 -> DONE, else decrement slot -> SCAN.
  - DONE: bank_valid[build bank] <= 1 if t < VACTIVE_LN -> IDLE.
- Priority: slots are drawn from high index to low, so a lower slot overwrites a higher one. Transparent pixels never overwrite.
- Cycle budget: worst case 640 + NSPRITES*(SPRITE_W+4) = 800 cycles, which is below 1600.
- Display path:
  - read column c = (hcount+2)[10:1] of the display bank.
  - RAM read is registered, then an output register follows; pix_cidx at hcount H shows column H[10:1] (2-cycle latency compensated by the look-ahead).
  - pix_cidx is forced 0 when vcount >= 480, c >= 640, or bank_valid[display bank] == 0.
- A write and a trigger in the same cycle: the write lands first and is visible to the build that starts.

Test Plan:
- Reset, slot 0 = {en, x=100, y=50, pattern 2}, ROM row = all 2'b01 -> line 50, columns 100..115 show pix_cidx=1; columns 99 and 116 show 0; lines 49 and 66 are all 0.
- Slots 0 and 1 overlap at the same x/y, slot0 ROM = 2'b10, slot1 = 2'b11 -> overlap shows 2. Set slot0 row pixels to 0 -> shows 3 (transparency).
- x=630 -> columns 630..639 drawn, no write wraps to column 0; y=470 -> lines 470..479 drawn, nothing drawn on lines 480..485.
- Check pixel alignment: rendered pixel at column 100 is present on pix_cidx during hcount 200 and 201, exactly.
- Assert reset during CLEAR -> outputs 0 immediately, enables cleared, nothing displayed until a full build completes; first frame after release correct.
- Frame wrap: sprite at y=0 -> build at vcount=524 fills bank 0, and line 0 displays correctly; render_overrun stays 0 for 8 sprites all hitting.
